pri_enc_always_reg: RTL and testbench
=====================================

Name: pri_enc_always_reg

Overview:
- Registered N-input priority encoder.
- Reports the binary index of the highest-priority asserted request bit on Y, plus a valid flag.
- Used wherever one of several request lines must be turned into a compact index, e.g. arbiter front-ends and interrupt index generation.
- One clock domain; all outputs are registered (one-cycle latency).

Parameters:
- WIDTH, 4: number of request inputs on Y; legal values are 2 and above.
- AW, $clog2(WIDTH): width of the index output A. Must be at least 1 and must equal $clog2(WIDTH). The default is computed from WIDTH; overriding it is not supported.
- MSB_FIRST, 1: priority order.
  - 1: highest index wins (Y[WIDTH-1] has top priority).
  - 0: lowest index wins (Y[0] has top priority).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: capture enable; outputs update only on cycles where en=1.
- Y, input, WIDTH: request vector.
- A, output, AW: encoded index of the winning request bit.
- valid, output, 1: 1 when at least one bit of the captured Y was set.

Behaviour:
- Reset:
  - On a rising clk edge with rst=1: A <= 0 and valid <= 0.
  - rst takes priority over en.
  - rst asserted mid-operation clears the outputs on the next edge regardless of Y.
- Capture:
  - On a rising edge with rst=0 and en=1, the outputs load the combinational encode of the current Y.
  - Latency: Y sampled at edge k is visible on A and valid after edge k.
  - With en=0 the outputs hold their previous values.
- Encode with MSB_FIRST=1:
  - A = the largest i such that Y[i]=1.
  - Lower bits are don't-care once a higher bit is set.
- Encode with MSB_FIRST=0:
  - A = the smallest i such that Y[i]=1.
- All-zero input:
  - Y=0 gives A=0 and valid=0.
  - A=0 with valid=0 is distinct from a genuine index-0 win, which gives A=0 with valid=1.
- Implementation constraints:
  - Encode logic is a combinational always block using loop- or case-based priority logic.
  - No latches: defaults are assigned before the priority scan.
- Widths:
  - For WIDTH not a power of two, A never exceeds WIDTH-1.
  - No X propagation: the outputs are fully defined whenever Y is fully defined.
- Y changing between edges has no effect on the outputs until the next enabled edge.

Optional Feature:
- Macro: PRI_ENC_ONEHOT_EN.
- When defined:
  - Adds output port G [WIDTH-1:0], registered alongside A.
  - G is the one-hot grant: only bit A is set when valid=1; G is all zeros when valid=0.
  - G resets to 0 and follows the same en/rst rules as A.
- When undefined:
  - Port G does not exist; all other behaviour is unchanged.

Test Plan:
- Reset: rst=1 for 2 cycles with Y=4'b1111, en=1 -> A=2'b00 and valid=0 at every edge while rst=1. Release rst -> A=2'b11 and valid=1 after the next edge.
- Exhaustive sweep: WIDTH=4, MSB_FIRST=1, en=1, Y from 0000 to 1111, one value per cycle. After the following edge:
  - 0000 -> A=00, valid=0.
  - 0001 -> A=00, valid=1.
  - 0010 and 0011 -> A=01.
  - 0100 to 0111 -> A=10.
  - 1000 to 1111 -> A=11.
  - valid=1 for every nonzero Y.
- LSB priority: MSB_FIRST=0 -> Y=1010 gives A=01; Y=1000 gives A=11; Y=0111 gives A=00; Y=0000 gives valid=0.
- Enable hold: capture Y=0100 (A=10); set en=0 and drive Y=1000 for 3 cycles -> A stays 10. Set en=1 -> A=11 after the next edge.
- Non-power-of-two: WIDTH=5 (AW=3) -> Y=5'b10000 gives A=3'd4; Y=5'b00110 gives A=3'd2; Y=0 gives valid=0.
- PRI_ENC_ONEHOT_EN defined, WIDTH=4 -> Y=0110 gives G=0100 and A=10; Y=0000 gives G=0000; rst gives G=0000.

Source files
------------

// File: rtl/pri_enc_always_reg.sv
// pri_enc_always_reg: registered priority encoder with valid flag; define PRI_ENC_ONEHOT_EN to add one-hot grant G.
module pri_enc_always_reg #(
  parameter int WIDTH = 4,
  parameter int AW = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] Y,
  output logic [AW-1:0]    A,
  output logic             valid
`ifdef PRI_ENC_ONEHOT_EN
  ,
  output logic [WIDTH-1:0] G
`endif
);
  logic [AW-1:0] a_n;
  logic          v_n;
  always_comb begin
    a_n = '0;
    v_n = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = MSB_FIRST ? i : WIDTH - 1 - i;
      if (Y[j]) begin
        a_n = AW'(j);
        v_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      A     <= '0;
      valid <= 1'b0;
    end else if (en) begin
      A     <= a_n;
      valid <= v_n;
    end
  end
`ifdef PRI_ENC_ONEHOT_EN
  logic [WIDTH-1:0] g_n;
  always_comb g_n = v_n ? (WIDTH'(1) << a_n) : '0;
  always_ff @(posedge clk) begin
    if (rst) G <= '0;
    else if (en) G <= g_n;
  end
`endif
endmodule

// File: tb/tb_pri_enc_always_reg.sv
// tb_pri_enc_always_reg: scoreboard bench for MSB-first, LSB-first and WIDTH=5 encoder instances.
module tb_pri_enc_always_reg;
  logic clk = 0, rst = 1, en = 0;
  logic [3:0] y4 = '0;
  logic [4:0] y5 = '0;
  logic [1:0] a0, a1;
  logic [2:0] a2;
  logic v0, v1, v2;
`ifdef PRI_ENC_ONEHOT_EN
  logic [3:0] g0, g1;
  logic [4:0] g2;
`endif
  int n_cmp = 0, n_fail = 0;
  logic [2:0] ma0 = 0, ma1 = 0, ma2 = 0;
  logic mv0 = 0, mv1 = 0, mv2 = 0;
  logic [22:0] sb[$];
  logic [22:0] x, got;

  always #5 clk = ~clk;

  pri_enc_always_reg #(.WIDTH(4), .MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .en(en), .Y(y4), .A(a0), .valid(v0)
`ifdef PRI_ENC_ONEHOT_EN
    , .G(g0)
`endif
  );
  pri_enc_always_reg #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .en(en), .Y(y4), .A(a1), .valid(v1)
`ifdef PRI_ENC_ONEHOT_EN
    , .G(g1)
`endif
  );
  pri_enc_always_reg #(.WIDTH(5), .MSB_FIRST(1)) u_w5 (.clk(clk), .rst(rst), .en(en), .Y(y5), .A(a2), .valid(v2)
`ifdef PRI_ENC_ONEHOT_EN
    , .G(g2)
`endif
  );

  function automatic logic [2:0] msb_idx(input int y);
    return (y == 0) ? 3'd0 : 3'($clog2(y + 1) - 1);
  endfunction

  function automatic logic [2:0] lsb_idx(input int y);
    return (y == 0) ? 3'd0 : 3'($clog2(y & -y));
  endfunction

  function automatic logic [22:0] pack_model();
    logic [22:0] p;
    logic [3:0] e0, e1;
    logic [4:0] e2;
    e0 = mv0 ? (4'd1 << ma0) : 4'd0;
    e1 = mv1 ? (4'd1 << ma1) : 4'd0;
    e2 = mv2 ? (5'd1 << ma2) : 5'd0;
    p[9:0] = {ma0[1:0], mv0, ma1[1:0], mv1, ma2, mv2};
`ifdef PRI_ENC_ONEHOT_EN
    p[22:10] = {e0, e1, e2};
`else
    p[22:10] = '0;
    if (e0 == e1 && e1 == 4'd15 && e2 == 5'd31) p[22:10] = '0;
`endif
    return p;
  endfunction

  function automatic logic [22:0] obs();
    logic [22:0] o;
    o[9:0] = {a0, v0, a1, v1, a2, v2};
    o[22:10] = '0;
`ifdef PRI_ENC_ONEHOT_EN
    o[22:10] = {g0, g1, g2};
`endif
    return o;
  endfunction

  task automatic apply(input logic r, input logic e, input logic [3:0] ya, input logic [4:0] yb);
    @(negedge clk);
    rst = r; en = e; y4 = ya; y5 = yb;
    if (r) begin
      ma0 = 0; ma1 = 0; ma2 = 0; mv0 = 0; mv1 = 0; mv2 = 0;
    end else if (e) begin
      ma0 = msb_idx(int'(ya)); mv0 = ya != 0;
      ma1 = lsb_idx(int'(ya)); mv1 = ya != 0;
      ma2 = msb_idx(int'(yb)); mv2 = yb != 0;
    end
    sb.push_back(pack_model());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(i < 2, 1'b1, 4'b1111, 5'b11111);
      x = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== x) begin n_fail++; $display("FAIL reset step=%0d got=%h exp=%h", i, got, x); end
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 1'b1, 4'(i), 5'(i));
      x = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== x) begin n_fail++; $display("FAIL sweep y=%0d got=%h exp=%h", i, got, x); end
    end
  endtask

  task automatic test_lsb();
    logic [3:0] t[4] = '{4'b1010, 4'b1000, 4'b0111, 4'b0000};
    logic [1:0] ea[4] = '{2'd1, 2'd3, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, t[i], 5'd0);
      x = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== x || a1 !== ea[i] || v1 !== (i != 3)) begin
        n_fail++; $display("FAIL lsb y=%b got a=%0d v=%b exp a=%0d v=%b", t[i], a1, v1, ea[i], i != 3);
      end
    end
  endtask

  task automatic test_enable_hold();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, i == 0 || i == 4, i == 0 ? 4'b0100 : 4'b1000, i == 0 ? 5'b00100 : 5'b10000);
      x = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== x || a0 !== (i == 4 ? 2'd3 : 2'd2)) begin
        n_fail++; $display("FAIL hold step=%0d got=%h a=%0d exp=%h", i, got, a0, x);
      end
    end
  endtask

  task automatic test_width5();
    logic [4:0] t[3] = '{5'b10000, 5'b00110, 5'b00000};
    logic [2:0] ea[3] = '{3'd4, 3'd2, 3'd0};
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 4'd0, t[i]);
      x = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== x || a2 !== ea[i] || v2 !== (i != 2)) begin
        n_fail++; $display("FAIL width5 y=%b got a=%0d v=%b exp a=%0d v=%b", t[i], a2, v2, ea[i], i != 2);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      apply(i == 1, 1'b1, i == 0 ? 4'b0110 : 4'b1111, 5'b01001);
      x = sb.pop_front(); got = obs(); n_cmp++;
      if (got !== x) begin n_fail++; $display("FAIL mid_reset step=%0d got=%h exp=%h", i, got, x); end
`ifdef PRI_ENC_ONEHOT_EN
      n_cmp++;
      if (g0 !== (i == 0 ? 4'b0100 : i == 1 ? 4'b0000 : 4'b1000)) begin
        n_fail++; $display("FAIL onehot step=%0d got g=%b", i, g0);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_lsb();
    test_enable_hold();
    test_width5();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
